// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : shared RV32 constants, fetch FSM encoding and fetch buffer entry
// Revision  : 1.0
// ============================================================================
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BXX   = 7'b1100011;
    localparam logic [6:0] OP_LXX   = 7'b0000011;
    localparam logic [6:0] OP_SXX   = 7'b0100011;
    localparam logic [6:0] OP_IXX   = 7'b0010011;
    localparam logic [6:0] OP_RXX   = 7'b0110011;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// ifetch_fifo : synchronous {pc, inst} buffer with push/pop/flush; flush wins
// Revision    : 1.0
// ============================================================================
module ifetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fetch_entry_t            wdata,
    output fetch_entry_t            rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero until first write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// ifetch_unit : PC holder issuing single-outstanding word fetches into a buffer
// Revision    : 1.0
// ============================================================================
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    ifetch_state_e      state;
    ifetch_state_e      state_nxt;
    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    fetch_pc_nxt;
    logic [XLEN-1:0]    inflight_pc;
    logic               drop;
    logic               drop_nxt;
    logic               gnt_take;
    logic               rsp_keep;
    logic               pop;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_after;
    logic               fifo_full;
    logic               fifo_empty;
    fetch_entry_t       wr_entry;
    fetch_entry_t       head;

    assign gnt_take    = (state == IF_REQ) & imem_gnt;
    // rvalid outside WAIT has nothing to pair with and is ignored.
    assign rsp_keep    = (state == IF_WAIT) & imem_rvalid & ~drop & ~redirect_valid;
    assign pop         = inst_valid & inst_ready;
    assign count_after = count + CW'(rsp_keep) - CW'(pop);

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        drop_nxt     = drop;
        unique case (state)
            IF_IDLE: begin
                if (!fifo_full) state_nxt = IF_REQ;
            end
            IF_REQ: begin
                if (imem_gnt) begin
                    fetch_pc_nxt = fetch_pc + XLEN'(4);
                    state_nxt    = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (imem_rvalid) begin
                    drop_nxt  = 1'b0;
                    state_nxt = (count_after < DEPTH_C) ? IF_REQ : IF_IDLE;
                end
            end
            default: state_nxt = IF_IDLE;
        endcase

        // A redirect overrides everything; a fetch still in flight is marked stale.
        if (redirect_valid) begin
            fetch_pc_nxt = word_align(redirect_pc);
            if (gnt_take || ((state == IF_WAIT) && !imem_rvalid)) begin
                drop_nxt  = 1'b1;
                state_nxt = IF_WAIT;
            end else begin
                drop_nxt  = 1'b0;
                state_nxt = IF_REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IF_IDLE;
            fetch_pc    <= word_align(RESET_PC);
            inflight_pc <= '0;
            drop        <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            drop     <= drop_nxt;
            if (gnt_take) inflight_pc <= fetch_pc;
        end
    end

    assign wr_entry = '{pc: inflight_pc, inst: imem_rdata};

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_keep),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign imem_req   = (state == IF_REQ);
    assign imem_addr  = fetch_pc;
    assign inst_valid = ~fifo_empty;
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// tb_ifetch_unit : directed checks of ordering, back-pressure, redirects, wrap, reset
// Revision       : 1.0
// ============================================================================
module tb_ifetch_unit;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    ifetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    int          n_checked  = 0;
    int          n_mismatch = 0;
    int unsigned lat;
    logic        gnt_en;
    logic        keep_mem;
    int unsigned cyc;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    mreq_t       mq[$];
    logic [63:0] got[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checked++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] exp_word(input logic [31:0] pc);
        return {pc, pc ^ KEY};
    endfunction

    function automatic logic [63:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic wait_got(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 64'(got.size() >= n), 64'd1);
    endtask

    task automatic do_reset();
        keep_mem       = 1'b0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    // Memory: grants when enabled, answers each granted word lat cycles later, in order.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        cyc         = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            imem_gnt = gnt_en;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mq[0].addr ^ KEY;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
            @(negedge clk);
            if (reset && !keep_mem) begin
                mq.delete();
            end else begin
                if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
                if (imem_req && imem_gnt) mq.push_back('{addr: imem_addr, due: cyc + lat});
            end
        end
    end

    always @(negedge clk) begin
        if (reset) got.delete();
        else if (inst_valid && inst_ready) got.push_back({inst_pc, inst_data});
    end

    initial begin
        logic seen;
        reset          = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        gnt_en         = 1'b1;
        lat            = 1;
        keep_mem       = 1'b0;

        // In-order stream, 1-cycle memory, consumer always ready
        tick();
        check_eq("rst_req",   64'(imem_req),   64'd0);
        check_eq("rst_addr",  64'(imem_addr),  64'd0);
        check_eq("rst_valid", 64'(inst_valid), 64'd0);
        check_eq("rst_data",  64'(inst_data),  64'd0);
        check_eq("rst_pc",    64'(inst_pc),    64'd0);
        do_reset();
        tick();
        check_eq("t1_req_e1",   64'({imem_req, imem_addr}), 64'({1'b1, 32'h0}));
        check_eq("t1_valid_e1", 64'(inst_valid), 64'd0);
        tick();
        check_eq("t1_valid_e2", 64'(inst_valid), 64'd0);
        tick();
        check_eq("t1_valid_e3", 64'(inst_valid), 64'd1);
        check_eq("t1_head_e3",  {inst_pc, inst_data}, exp_word(32'h0));
        wait_got("t1_got", 5, 40);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("t1_seq%0d", i), got_at(i), exp_word(32'(4 * i)));

        // Back-pressure: buffer fills to depth, fetching stops
        inst_ready = 1'b0;
        do_reset();
        tick(10);
        check_eq("t2_req_full",   64'(imem_req),   64'd0);
        check_eq("t2_valid_full", 64'(inst_valid), 64'd1);
        check_eq("t2_head",       {inst_pc, inst_data}, exp_word(32'h0));
        check_eq("t2_none_taken", 64'(got.size()), 64'd0);
        gnt_en     = 1'b0;
        inst_ready = 1'b1;
        tick(6);
        check_eq("t2_buffered", 64'(got.size()), 64'd2);
        check_eq("t2_seq0", got_at(0), exp_word(32'h0));
        check_eq("t2_seq1", got_at(1), exp_word(32'h4));
        gnt_en = 1'b1;
        wait_got("t2_got", 6, 40);
        for (int i = 2; i < 6; i++)
            check_eq($sformatf("t2_seq%0d", i), got_at(i), exp_word(32'(4 * i)));

        // Redirect while waiting on a 3-cycle memory
        lat = 3;
        do_reset();
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        check_eq("t3_valid_after", 64'(inst_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | inst_valid;
        end
        check_eq("t3_no_stale", 64'(seen), 64'd0);
        tick();
        check_eq("t3_first", {inst_pc, inst_data}, exp_word(32'h100));
        wait_got("t3_got", 2, 40);
        check_eq("t3_seq0", got_at(0), exp_word(32'h100));
        check_eq("t3_seq1", got_at(1), exp_word(32'h104));

        // Redirect in the same cycle as gnt
        lat = 1;
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        wait_got("t4a_got", 2, 40);
        check_eq("t4a_seq0", got_at(0), exp_word(32'h200));
        check_eq("t4a_seq1", got_at(1), exp_word(32'h204));

        // Redirect in the same cycle as rvalid
        do_reset();
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        wait_got("t4b_got", 2, 40);
        check_eq("t4b_seq0", got_at(0), exp_word(32'h300));
        check_eq("t4b_seq1", got_at(1), exp_word(32'h304));

        // PC wrap at the top of the address space
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_got("t5_got", 3, 40);
        check_eq("t5_seq0", got_at(0), exp_word(32'hFFFF_FFFC));
        check_eq("t5_seq1", got_at(1), exp_word(32'h0000_0000));
        check_eq("t5_seq2", got_at(2), exp_word(32'h0000_0004));

        // Reset mid-WAIT; the old response arrives after release and must vanish
        lat = 4;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        tick();
        keep_mem = 1'b1;
        gnt_en   = 1'b0;
        reset    = 1'b1;
        #1;
        check_eq("t6_rst_req",   64'(imem_req),   64'd0);
        check_eq("t6_rst_addr",  64'(imem_addr),  64'd0);
        check_eq("t6_rst_valid", 64'(inst_valid), 64'd0);
        check_eq("t6_rst_data",  64'(inst_data),  64'd0);
        check_eq("t6_rst_pc",    64'(inst_pc),    64'd0);
        tick();
        reset = 1'b0;
        tick(4);
        check_eq("t6_no_late",     64'({inst_valid, 8'(got.size())}), 64'd0);
        check_eq("t6_addr_restart", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h0}));
        gnt_en = 1'b1;
        wait_got("t6_got", 2, 40);
        check_eq("t6_seq0", got_at(0), exp_word(32'h0));
        check_eq("t6_seq1", got_at(1), exp_word(32'h4));
        keep_mem = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_mismatch);
        $finish;
    end

endmodule
`default_nettype wire
